// File: rtl/multicycle_pkg.sv
// Shared types and constants for the multicycle RV32 control unit.
package multicycle_pkg;

    localparam int unsigned OP_W    = 7;
    localparam int unsigned ALUOP_W = 2;
    localparam int unsigned F7_W    = 7;
    localparam int unsigned MCNT_W  = 8;

    localparam logic [OP_W-1:0] OP_R      = 7'b0110011;
    localparam logic [OP_W-1:0] OP_I      = 7'b0010011;
    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;

    localparam logic [F7_W-1:0] F7_MULDIV = 7'b0000001;

    localparam logic [ALUOP_W-1:0] R_OP     = 2'b10;
    localparam logic [ALUOP_W-1:0] B_OP     = 2'b01;
    localparam logic [ALUOP_W-1:0] OTHER_OP = 2'b00;

    // Datapath mux selects
    localparam logic SRC_REG  = 1'b0;
    localparam logic SRC_IMM  = 1'b1;
    localparam logic WB_ALU   = 1'b0;
    localparam logic WB_MEM   = 1'b1;
    localparam logic ADDR_PC  = 1'b0;
    localparam logic ADDR_ALU = 1'b1;

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP
    } state_e;

    typedef struct packed {
        logic               legal;
        logic [ALUOP_W-1:0] alu_op;
        logic               alu_src;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic               needs_wb;
    } dec_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Instruction-register / datapath / memory signals of the control unit.
interface multicycle_control_if #(
    parameter int unsigned CNT_W = 32
) ();
    import multicycle_pkg::*;

    logic               start_i;
    logic [OP_W-1:0]    Op_i;
    logic [F7_W-1:0]    Funct7_i;
    logic               Zero_i;
    logic               mem_ready_i;

    logic               PCWrite_o;
    logic               PCSrc_o;
    logic               IorD_o;
    logic               IRWrite_o;
    logic               MemRead_o;
    logic               MemWrite_o;
    logic               MemtoReg_o;
    logic [ALUOP_W-1:0] ALUOp_o;
    logic               ALUSrc_o;
    logic               RegWrite_o;
    logic               busy_o;
    logic               illegal_o;
    logic [CNT_W-1:0]   retired_o;

    modport master (
        input  start_i, Op_i, Funct7_i, Zero_i, mem_ready_i,
        output PCWrite_o, PCSrc_o, IorD_o, IRWrite_o, MemRead_o, MemWrite_o,
               MemtoReg_o, ALUOp_o, ALUSrc_o, RegWrite_o, busy_o, illegal_o,
               retired_o
    );

    modport slave (
        output start_i, Op_i, Funct7_i, Zero_i, mem_ready_i,
        input  PCWrite_o, PCSrc_o, IorD_o, IRWrite_o, MemRead_o, MemWrite_o,
               MemtoReg_o, ALUOp_o, ALUSrc_o, RegWrite_o, busy_o, illegal_o,
               retired_o
    );

endinterface

// File: rtl/control_decode.sv
// Opcode to per-instruction control fields; the FSM gates these by state.
module control_decode
    import multicycle_pkg::*;
(
    input  logic [OP_W-1:0] op_i,
    output dec_t            dec_o
);

    always_comb begin
        dec_o = '0;
        case (op_i)
            OP_R: begin
                dec_o.legal    = 1'b1;
                dec_o.alu_op   = R_OP;
                dec_o.alu_src  = SRC_REG;
                dec_o.needs_wb = 1'b1;
            end
            OP_I: begin
                dec_o.legal    = 1'b1;
                dec_o.alu_op   = OTHER_OP;
                dec_o.alu_src  = SRC_IMM;
                dec_o.needs_wb = 1'b1;
            end
            OP_LOAD: begin
                dec_o.legal      = 1'b1;
                dec_o.alu_op     = OTHER_OP;
                dec_o.alu_src    = SRC_IMM;
                dec_o.mem_read   = 1'b1;
                dec_o.mem_to_reg = WB_MEM;
                dec_o.needs_wb   = 1'b1;
            end
            OP_STORE: begin
                dec_o.legal     = 1'b1;
                dec_o.alu_op    = OTHER_OP;
                dec_o.alu_src   = SRC_IMM;
                dec_o.mem_write = 1'b1;
            end
            OP_BRANCH: begin
                dec_o.legal   = 1'b1;
                dec_o.alu_op  = B_OP;
                dec_o.alu_src = SRC_REG;
            end
            default: dec_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32 control FSM: FETCH/DECODE/EXECUTE/MEM/WRITEBACK with
// M-extension stretch, illegal-opcode trap and retired-instruction counter.
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    multicycle_control_if.master  bus
);

    state_e              state_q, state_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [MCNT_W-1:0]   mcnt_q, mcnt_d;
    logic [CNT_W-1:0]    retired_q, retired_d;
    logic                seen_low_q, seen_low_d;

    logic [OP_W-1:0]     dec_op;
    dec_t                dec;
    logic                is_mul;
    state_e              end_state;

    logic                pc_write_c, pc_src_c, iord_c, ir_write_c;
    logic                mem_read_c, mem_write_c, mem_to_reg_c;
    logic [ALUOP_W-1:0]  alu_op_c;
    logic                alu_src_c, reg_write_c, retire_c;

    // Decode straight from the IR while in DECODE, from the latch afterwards
    assign dec_op    = (state_q == DECODE) ? bus.Op_i : op_q;
    assign is_mul    = (bus.Op_i == OP_R) && (bus.Funct7_i == F7_MULDIV);
    assign end_state = bus.start_i ? FETCH : IDLE;

    control_decode u_decode (
        .op_i  (dec_op),
        .dec_o (dec)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            op_q       <= '0;
            mcnt_q     <= '0;
            retired_q  <= '0;
            seen_low_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            mcnt_q     <= mcnt_d;
            retired_q  <= retired_d;
            seen_low_q <= seen_low_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        mcnt_d       = mcnt_q;
        seen_low_d   = 1'b0;
        retire_c     = 1'b0;
        pc_write_c   = 1'b0;
        pc_src_c     = 1'b0;
        iord_c       = ADDR_PC;
        ir_write_c   = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        mem_to_reg_c = WB_ALU;
        alu_op_c     = OTHER_OP;
        alu_src_c    = SRC_REG;
        reg_write_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start_i) state_d = FETCH;
            end
            FETCH: begin
                mem_read_c = 1'b1;
                if (bus.mem_ready_i) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = DECODE;
                end
            end
            DECODE: begin
                op_d = bus.Op_i;
                if (!dec.legal) begin
                    state_d = TRAP;
                end else begin
                    state_d = EXECUTE;
                    mcnt_d  = is_mul ? MCNT_W'(MUL_CYCLES - 1) : '0;
                end
            end
            EXECUTE: begin
                alu_op_c  = dec.alu_op;
                alu_src_c = dec.alu_src;
                if (mcnt_q != '0) begin
                    mcnt_d = mcnt_q - MCNT_W'(1);
                end else if (dec.mem_read || dec.mem_write) begin
                    state_d = MEM;
                end else if (dec.needs_wb) begin
                    state_d = WRITEBACK;
                end else begin
                    // Branch resolves and retires here
                    pc_write_c = bus.Zero_i;
                    pc_src_c   = 1'b1;
                    retire_c   = 1'b1;
                    state_d    = end_state;
                end
            end
            MEM: begin
                iord_c      = ADDR_ALU;
                mem_read_c  = dec.mem_read;
                mem_write_c = dec.mem_write;
                if (bus.mem_ready_i) begin
                    if (dec.needs_wb) begin
                        state_d = WRITEBACK;
                    end else begin
                        retire_c = 1'b1;
                        state_d  = end_state;
                    end
                end
            end
            WRITEBACK: begin
                reg_write_c  = 1'b1;
                mem_to_reg_c = dec.mem_to_reg;
                retire_c     = 1'b1;
                state_d      = end_state;
            end
            TRAP: begin
                // Leave only on a fresh 0->1 of start_i seen while trapped
                seen_low_d = seen_low_q | ~bus.start_i;
                if (bus.start_i && seen_low_q) state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase

        retired_d = retire_c ? retired_q + CNT_W'(1) : retired_q;
    end

    assign bus.PCWrite_o  = pc_write_c;
    assign bus.PCSrc_o    = pc_src_c;
    assign bus.IorD_o     = iord_c;
    assign bus.IRWrite_o  = ir_write_c;
    assign bus.MemRead_o  = mem_read_c;
    assign bus.MemWrite_o = mem_write_c;
    assign bus.MemtoReg_o = mem_to_reg_c;
    assign bus.ALUOp_o    = alu_op_c;
    assign bus.ALUSrc_o   = alu_src_c;
    assign bus.RegWrite_o = reg_write_c;
    assign bus.busy_o     = (state_q != IDLE) && (state_q != TRAP);
    assign bus.illegal_o  = (state_q == TRAP);
    assign bus.retired_o  = retired_q;

endmodule
